// File: rtl/multiport_memory.sv
// multiport_memory: parametrised multi-port memory with priority writes, registered write-first reads
// and a post-reset hardware clear sequence.
module multiport_memory #(
  parameter int WIDTH      = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int PORTS      = 9,
  parameter int IDX_SHIFT  = 5
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [PORTS-1:0]            writeEnable,
  input  logic [PORTS*WIDTH-1:0]      dataIn,
  output logic [PORTS*WIDTH-1:0]      data,
  output logic                        ready,
  output logic                        conflict,
  output logic [PORTS-1:0]            oob
);
  localparam int CW = $clog2(DEPTH);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] idx [PORTS];
  logic [PORTS-1:0] inr, wv;
  logic [PORTS*WIDTH-1:0] data_d;
  logic conflict_d;
  for (genvar i = 0; i < PORTS; i++) begin : g_port
    assign idx[i] = addr[i*ADDR_WIDTH +: ADDR_WIDTH] >> IDX_SHIFT;
    assign inr[i] = idx[i] < ADDR_WIDTH'(DEPTH);
    assign wv[i]  = state == RUN && writeEnable[i] && inr[i];
  end
  always_comb begin
    state_d = (state == CLEAR && cnt == CW'(DEPTH - 1)) ? RUN : state;
    cnt_d   = (state == CLEAR && cnt != CW'(DEPTH - 1)) ? cnt + 1'b1 : cnt;
  end
  // ascending port order makes the highest-numbered writer win; reads see the post-write words
  always_comb begin
    mem_d      = mem;
    conflict_d = 1'b0;
    data_d     = '0;
    if (state == CLEAR) mem_d[cnt] = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (wv[p]) mem_d[idx[p][CW-1:0]] = dataIn[p*WIDTH +: WIDTH];
      for (int q = p + 1; q < PORTS; q++)
        if (wv[p] && wv[q] && idx[p] == idx[q]) conflict_d = 1'b1;
    end
    for (int p = 0; p < PORTS; p++)
      data_d[p*WIDTH +: WIDTH] = (state == RUN && inr[p]) ? mem_d[idx[p][CW-1:0]] : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= CLEAR;
      cnt      <= '0;
      data     <= '0;
      conflict <= 1'b0;
      oob      <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      data     <= data_d;
      conflict <= conflict_d;
      oob      <= ~inr;
    end
  always_ff @(posedge clk) mem <= mem_d;
  assign ready = state == RUN;
endmodule

// File: tb/tb_multiport_memory.sv
// tb_multiport_memory: directed plus randomized checks of multiport_memory against a word-array model.
module tb_multiport_memory;
  localparam int W = 5, AW = 32, D = 16, P = 9, S = 5;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [P*AW-1:0] addr;
  logic [P-1:0] we;
  logic [P*W-1:0] din;
  logic [P*W-1:0] data;
  logic ready, conflict;
  logic [P-1:0] oob;
  int errors = 0, checks = 0;
  logic [W-1:0] mm [D];
  int e;
  logic [P*W-1:0] xd;
  logic xc;
  logic [P-1:0] xo;
  logic xo_valid;

  multiport_memory dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .writeEnable(we), .dataIn(din),
    .data(data), .ready(ready), .conflict(conflict), .oob(oob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic w, input logic [W-1:0] d);
    addr[p*AW +: AW] = a;
    we[p] = w;
    din[p*W +: W] = d;
  endtask

  task automatic idle();
    addr = '0;
    we = '0;
    din = '0;
  endtask

  // Applies one clock edge of the specified behaviour to the model using the current inputs.
  task automatic model_edge();
    int hits [D];
    logic [AW-1:0] ix;
    xd = '0;
    xc = 1'b0;
    for (int p = 0; p < P; p++) begin
      ix = addr[p*AW +: AW] >> S;
      xo[p] = ix >= D;
    end
    if (e < D) begin
      mm[e] = '0;
      e++;
      xo_valid = 1'b0;
    end else begin
      for (int i = 0; i < D; i++) hits[i] = 0;
      for (int p = 0; p < P; p++) begin
        ix = addr[p*AW +: AW] >> S;
        if (we[p] && ix < D) begin
          mm[int'(ix)] = din[p*W +: W];
          hits[int'(ix)]++;
        end
      end
      for (int i = 0; i < D; i++) if (hits[i] > 1) xc = 1'b1;
      for (int p = 0; p < P; p++) begin
        ix = addr[p*AW +: AW] >> S;
        xd[p*W +: W] = (ix < D) ? mm[int'(ix)] : '0;
      end
      xo_valid = 1'b1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("data", data, xd);
    chk("ready", ready, e >= D);
    chk("conflict", conflict, xc);
    if (xo_valid) chk("oob", oob, xo);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_data"}, data, 0);
    chk({n, "_ready"}, ready, 0);
    chk({n, "_conflict"}, conflict, 0);
    chk({n, "_oob"}, oob, 0);
  endtask

  task automatic clear_phase(input string n);
    we = '1;
    din = {P{5'h1f}};
    for (int p = 0; p < P; p++) addr[p*AW +: AW] = AW'(32 * p);
    for (int k = 1; k <= D; k++) begin
      step();
      if (k == D - 1) chk({n, "_ready_edge15"}, ready, 0);
      if (k == D) chk({n, "_ready_edge16"}, ready, 1);
    end
    idle();
  endtask

  task automatic readback();
    for (int b = 0; b < 2; b++) begin
      idle();
      for (int p = 0; p < P; p++)
        addr[p*AW +: AW] = (b * P + p < D) ? AW'(32 * (b * P + p)) : '0;
      step();
    end
  endtask

  initial begin
    int hi;
    idle();
    e = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    clear_phase("clear1");

    set_port(0, 0, 1'b0, 5'h1f);
    step();
    chk("nowrite_data0", data[0 +: W], 0);

    for (int p = 0; p < P; p++) set_port(p, AW'(32 * p), 1'b1, W'(5'h1f - p));
    step();
    for (int p = 0; p < P; p++) chk("parallel_data", data[p*W +: W], W'(5'h1f - p));
    chk("parallel_conflict", conflict, 0);

    idle();
    set_port(2, 64, 1'b1, 5'h03);
    set_port(5, 64, 1'b1, 5'h05);
    set_port(7, 64, 1'b1, 5'h07);
    set_port(0, 64, 1'b0, 5'h00);
    step();
    chk("collide_data0", data[0 +: W], 5'h07);
    chk("collide_conflict", conflict, 1);
    idle();
    step();
    chk("collide_conflict_drop", conflict, 0);

    set_port(4, 512, 1'b1, 5'h1b);
    step();
    chk("oob_flag4", oob[4], 1);
    chk("oob_data4", data[4*W +: W], 0);
    idle();
    step();
    chk("oob_drop", oob, 0);

    readback();
    idle();
    for (int p = 0; p < P; p++) addr[p*AW +: AW] = AW'(32 * p);
    step();
    chk("readback_word2", data[2*W +: W], 5'h07);
    chk("readback_word8", data[8*W +: W], 5'h17);

    #3 reset_n = 1'b0;
    #1 chk_zero("midreset");
    e = 0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    clear_phase("clear2");
    readback();
    chk("cleared_word15", data[6*W +: W], 0);

    for (int n = 0; n < 400; n++) begin
      hi = $urandom_range(0, 1) ? 5 : 19;
      for (int p = 0; p < P; p++)
        set_port(p, ($urandom_range(0, 15) == 0) ? AW'($urandom) :
                    AW'($urandom_range(0, hi) * 32 + $urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), W'($urandom_range(0, 31)));
      step();
    end
    idle();
    readback();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/multiport_memory.md
# multiport_memory

Parametrised multi-port data memory for the datapath. It generalises the fixed 9-port data memory: port count, word width, depth and address stride are parameters, and every port has its own write enable. Reads are registered and write-first. Same-cycle write collisions follow a fixed priority. After reset, a hardware clear sequence zeroes every word, and a `ready` flag reports when that sequence has finished.

## Interface
- `WIDTH`, 5, data word width in bits
- `ADDR_WIDTH`, 32, width of each port address
- `DEPTH`, 16, number of words (≥2)
- `PORTS`, 9, number of independent read/write ports (≥1)
- `IDX_SHIFT`, 5, word index = addr >> IDX_SHIFT (stride 32 per word)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `addr`  in  PORTS*ADDR_WIDTH  packed port addresses; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
- `writeEnable`  in  PORTS  per-port write enable
- `dataIn`  in  PORTS*WIDTH  packed write data; port p at [p*WIDTH +: WIDTH]
- `data`  out  PORTS*WIDTH  packed registered read data
- `ready`  out  1  high once the clear sequence is complete
- `conflict`  out  1  registered; ≥2 enabled ports wrote the same index last cycle
- `oob`  out  PORTS  registered per-port out-of-range flag

## Operation
- Index: idx_p = addr_p >> IDX_SHIFT. An address is out of range when idx_p ≥ DEPTH.
- FSM states:
  - CLEAR: clear counter cnt walks 0..DEPTH-1 and writes 0 to word cnt each cycle. User writes are ignored. `data` holds 0.
  - RUN: normal operation.
- CLEAR → RUN on the edge that clears word DEPTH-1. There is no exit from RUN except reset.
- Write (RUN): on each edge, every port with writeEnable_p=1 and idx_p in range writes dataIn_p to mem[idx_p].
- Collision: when several enabled ports target the same index, the highest-numbered port wins. `conflict` is 1 for the following cycle.
- Out-of-range write: dropped, memory unchanged. oob_p=1 the following cycle, regardless of writeEnable.
- Read (RUN): each edge, data_p is loaded with the post-write value of mem[idx_p] (write-first, including writes from other ports that same edge). An out-of-range read loads 0.
- Reset mid-operation: state returns to CLEAR and cnt to 0. All memory words are re-cleared once reset_n is released.

## Timing
- Reset values while reset_n=0 (asynchronous):
  - `data`=0, `ready`=0, `conflict`=0, `oob`=0
  - state=CLEAR, cnt=0
- Memory contents are not reset asynchronously; they are zeroed by CLEAR.
- Clear length: the k-th rising edge after reset_n rises (k=1..DEPTH) clears word k-1. `ready` goes high on edge DEPTH.
- First accepted write: edge DEPTH+1.
- Read latency: 1 cycle. Inputs sampled at edge n appear on `data` after edge n.
- A write at edge n and a read of the same index at edge n return the written value after edge n.
- `conflict` and `oob` are valid 1 cycle after the sampled inputs and last 1 cycle unless the condition repeats.
- cnt is $clog2(DEPTH) bits and never wraps past DEPTH-1.
- The index comparison uses the full-width idx_p; no truncation.

## Test plan
- Reset → clear: hold reset_n=0 for 3 cycles, release, sample each edge. Required:
  - `ready`=0 through edge 15, `ready`=1 at edge 16 (DEPTH=16)
  - every mem word = 0
  - writes with writeEnable=1, dataIn=5'h1f during CLEAR are ignored
- No-write: writeEnable=0, dataIn0=5'h1f, addr0=0, one cycle → data0=0, mem[0]=0.
- Parallel write: ports p=0..8 with addr=32*p, dataIn=5'h1f-p, writeEnable=all 1. Required:
  - mem[p]=5'h1f-p
  - next cycle data_p=5'h1f-p
  - `conflict`=0
- Collision and write-first: ports 2, 5, 7 all write addr 64 with data 5'h03, 5'h05, 5'h07, while port 0 reads addr 64. Required:
  - mem[2]=5'h07
  - data0=5'h07 after that edge
  - `conflict`=1 for exactly 1 cycle
- Out of range: port 4 writes addr 32*16=512 with 5'h1b. Required:
  - no word changes
  - oob[4]=1 for 1 cycle
  - data4=0
- Reset mid-run: after the parallel-write test, pulse reset_n low for 1 cycle, asynchronously mid-cycle. Required:
  - all outputs 0 immediately
  - `ready` high again exactly 16 edges after release
  - all words 0
